// File: rtl/vfd_grid_capture.sv
// VFD grid/segment capture: filters MCU grid+segment outputs, keeps a per-grid
// segment image with expiry, and publishes a double-buffered frame for video.

module vfd_grid_lane #(
  parameter int SEGS    = 16,
  parameter int TIMEOUT = 64,
  parameter int AW      = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_sample_en,
  input  logic            i_commit,
  input  logic            i_strobe,
  input  logic [SEGS-1:0] i_seg,
  output logic [SEGS-1:0] o_work
);
  logic [AW-1:0] r_age;
  logic [AW-1:0] w_age_inc;

  // Age saturates at TIMEOUT so a long-dark grid never wraps back to "fresh".
  assign w_age_inc = (r_age == AW'(TIMEOUT)) ? r_age : r_age + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_age  <= '0;
      o_work <= '0;
    end else if (i_sample_en) begin
      if (i_commit && i_strobe) begin
        o_work <= i_seg;
        r_age  <= '0;
      end else begin
        r_age <= w_age_inc;
        if (w_age_inc == AW'(TIMEOUT)) o_work <= '0;
      end
    end
  end
endmodule

module vfd_grid_capture #(
  parameter int GRIDS     = 16,
  parameter int SEGS      = 16,
  parameter int SETTLE    = 2,
  parameter int TIMEOUT   = 64,
  parameter int FRAME_LEN = 1666
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic [GRIDS-1:0]         grid_i,
  input  logic [SEGS-1:0]          seg_i,
  input  logic [$clog2(GRIDS)-1:0] rd_addr,
  output logic [SEGS-1:0]          rd_data,
  output logic                     frame_o
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int AW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(FRAME_LEN);

  logic [GRIDS+SEGS-1:0]       r_prev;
  logic [SW-1:0]               r_stable;
  logic [SW-1:0]               w_stable_next;
  logic                        w_commit;
  logic [GRIDS-1:0][SEGS-1:0]  w_work;
  logic [GRIDS-1:0][SEGS-1:0]  r_disp;
  logic [FW-1:0]               r_frm;
  logic                        w_frm_last;

  // Ghost filter: a grid/segment pair must repeat SETTLE extra samples before use.
  always_comb begin
    w_stable_next = '0;
    if ({grid_i, seg_i} == r_prev)
      w_stable_next = (r_stable == SW'(SETTLE)) ? r_stable : r_stable + 1'b1;
  end

  assign w_commit   = (w_stable_next == SW'(SETTLE));
  assign w_frm_last = (r_frm == FW'(FRAME_LEN - 1));

  for (genvar g = 0; g < GRIDS; g++) begin : g_lane
    vfd_grid_lane #(.SEGS(SEGS), .TIMEOUT(TIMEOUT), .AW(AW)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_sample_en(sample_en),
      .i_commit   (w_commit),
      .i_strobe   (grid_i[g]),
      .i_seg      (seg_i),
      .o_work     (w_work[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev   <= '0;
      r_stable <= '0;
      r_disp   <= '0;
      r_frm    <= '0;
      rd_data  <= '0;
      frame_o  <= 1'b0;
    end else begin
      rd_data <= r_disp[rd_addr];
      frame_o <= sample_en & w_frm_last;
      if (sample_en) begin
        r_prev   <= {grid_i, seg_i};
        r_stable <= w_stable_next;
        // Publish uses pre-edge work, so a same-sample commit lands next frame.
        if (w_frm_last) begin
          r_disp <= w_work;
          r_frm  <= '0;
        end else begin
          r_frm <= r_frm + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vfd_grid_capture.sv
// Directed bench for vfd_grid_capture: settle, ghost reject, timeout, multi-grid
// publish alignment and reset behaviour with SETTLE=2, TIMEOUT=8, FRAME_LEN=16.

module tb_vfd_grid_capture;
  logic        clk;
  logic        reset;
  logic        sample_en;
  logic [15:0] grid_i;
  logic [15:0] seg_i;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        frame_o;

  int n_chk = 0;
  int n_err = 0;
  int n_pulse = 0;
  int mfrm = 0;
  int p0;

  vfd_grid_capture #(
    .GRIDS(16), .SEGS(16), .SETTLE(2), .TIMEOUT(8), .FRAME_LEN(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .grid_i   (grid_i),
    .seg_i    (seg_i),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .frame_o  (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_o === 1'b1) n_pulse++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One MCU sample: sample_en high for one clk, then three idle clks.
  task automatic do_sample(input logic [15:0] g, input logic [15:0] s);
    logic exp_f;
    @(negedge clk);
    grid_i = g; seg_i = s; sample_en = 1'b1;
    exp_f = (mfrm == 15);
    mfrm  = exp_f ? 0 : mfrm + 1;
    @(negedge clk);
    sample_en = 1'b0;
    chk("frame_o", {31'd0, frame_o}, {31'd0, exp_f});
    @(negedge clk);
    if (exp_f) chk("frame_o_1clk", {31'd0, frame_o}, 32'd0);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [15:0] g, input logic [15:0] s);
    for (int i = 0; i < n; i++) do_sample(g, s);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] e);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    chk(tag, {16'd0, rd_data}, {16'd0, e});
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; grid_i = '0; seg_i = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    chk("rst_frame_o", {31'd0, frame_o}, 32'd0);

    // Idle: single frame at sample 16, blank buffer.
    run(20, 16'h0000, 16'h0000);
    for (int a = 0; a < 16; a++) rd("idle_rd", 4'(a), 16'h0000);

    // Settle: third identical sample (32) commits, but publish at 32 sees old work.
    run(9, 16'h0000, 16'h0000);
    run(3, 16'h0004, 16'h00A5);
    rd("settle_pre", 4'd2, 16'h0000);
    run(16, 16'h0004, 16'h00A5);
    rd("settle_a2", 4'd2, 16'h00A5);
    rd("settle_a0", 4'd0, 16'h0000);
    rd("settle_a3", 4'd3, 16'h0000);

    // Ghost: alternating segments never settle; grid 2 expires meanwhile.
    for (int i = 0; i < 16; i++) do_sample(16'h0001, (i % 2 == 0) ? 16'h00FF : 16'h0011);
    rd("ghost_a0", 4'd0, 16'h0000);
    rd("expire_a2", 4'd2, 16'h0000);

    // Timeout: commit at 72, still present at age 7 when frame 80 publishes.
    run(5, 16'h0000, 16'h0000);
    run(3, 16'h0008, 16'h1234);
    run(8, 16'h0000, 16'h0000);
    rd("tmo_age7", 4'd3, 16'h1234);
    // Commit at 87, cleared at age 8 on sample 95, frame 96 shows 0.
    run(4, 16'h0000, 16'h0000);
    run(3, 16'h0008, 16'h1234);
    run(9, 16'h0000, 16'h0000);
    rd("tmo_age8", 4'd3, 16'h0000);
    // Re-commit on the 7th sample after the previous one keeps the value.
    run(3, 16'h0008, 16'h1234);
    run(4, 16'h0000, 16'h0000);
    run(3, 16'h0008, 16'h1234);
    run(6, 16'h0000, 16'h0000);
    rd("restrobe", 4'd3, 16'h1234);

    // Multi-grid commit landing on the publish sample (128).
    run(13, 16'h0000, 16'h0000);
    run(3, 16'h8001, 16'hBEEF);
    rd("multi_old_a0", 4'd0, 16'h0000);
    rd("multi_old_a15", 4'd15, 16'h0000);
    rd("tmo_next_a3", 4'd3, 16'h0000);
    run(16, 16'h8001, 16'hBEEF);
    rd("multi_a0", 4'd0, 16'hBEEF);
    rd("multi_a15", 4'd15, 16'hBEEF);
    rd("multi_a1", 4'd1, 16'h0000);

    // Reset mid-frame at frm_cnt=9.
    run(9, 16'h8001, 16'hBEEF);
    rd("pre_rst_a0", 4'd0, 16'hBEEF);
    p0 = n_pulse;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_no_frame", n_pulse, p0);
    mfrm = 0;
    rd("post_rst_a0", 4'd0, 16'h0000);
    rd("post_rst_a15", 4'd15, 16'h0000);
    run(16, 16'h0000, 16'h0000);

    // Reset on the very edge that would publish suppresses frame_o.
    run(15, 16'h0000, 16'h0000);
    @(negedge clk);
    grid_i = '0; seg_i = '0; sample_en = 1'b1; reset = 1'b1;
    @(negedge clk);
    sample_en = 1'b0; reset = 1'b0;
    chk("rst_on_publish", {31'd0, frame_o}, 32'd0);
    mfrm = 0;
    repeat (2) @(negedge clk);
    run(16, 16'h0000, 16'h0000);

    chk("pulse_total", n_pulse, 11);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
